translate_predict_multi: RTL and testbench
==========================================

TRANSLATE_PREDICT_MULTI -- requirements
Module: translate_predict_multi

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, number of prediction-table entries (power of two, 2..16).
REQ-002 SHALL have parameter MASK_W, default 16, page-mask width covering VA bits [27:12].
REQ-003 SHALL have parameter ASID_W, default 8, address-space identifier width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  hold all state while high.
REQ-007 SHALL have port inval  input  1  clear all table entries (TLB write, ASID reload).
REQ-008 SHALL have port asid  input  ASID_W  current address space.
REQ-009 SHALL have port vPC  input  32  virtual fetch address for this cycle.
REQ-010 SHALL have ports pageMask  input  MASK_W  and pPCin  input  32; TLB result for this cycle's vPC.
REQ-011 SHALL have port pPCOut  output  32  predicted, or corrected, physical fetch address.
REQ-012 SHALL have port flush  output  1  previous cycle's prediction was wrong.

Function
REQ-013 SHALL hold per entry: valid, asid, vpn[27:12], mask, ppn[31:12].
REQ-014 Lookup SHALL be combinational and fully associative; an entry hits when valid, asid matches, and vpn & ~mask == vPC[27:12] & ~mask; on multiple hits the lowest index SHALL win.
REQ-015 Hit prediction SHALL be {ppn[31:28], (ppn[27:12]&~mask)|(vPC[27:12]&mask), vPC[11:0]}.
REQ-016 Miss prediction SHALL use the last-translation registers (pPC_last, mask_last) with the same merge formula.
REQ-017 While not stalled, each edge SHALL register pPCin, pageMask, asid, vPC, the prediction, and the hit index / hit flag.
REQ-018 flush SHALL be combinational: registered pPCin != registered prediction; pPCOut SHALL be registered pPCin when flush=1, otherwise the current prediction.
REQ-019 On a non-stalled edge with flush=1, the table SHALL be written from the registered values: the hit entry if the registered hit flag was set, else the round-robin victim; the pointer SHALL advance mod ENTRIES only when the victim is used.
REQ-020 inval SHALL clear all valid bits on the next edge regardless of stall, and SHALL take priority over a simultaneous write; the last-translation registers are unaffected.
REQ-021 Latency SHALL be zero cycles for prediction and one cycle for flush detection; flush SHALL never assert in two consecutive cycles for the same registered pair while stalled (outputs hold).

Reset
REQ-022 On rst_n low: all valid=0, round-robin pointer=0, pPC_last and registered prediction=32'h1fc00000, mask_last=all ones, hit flag=0; therefore flush=0 and pPCOut=miss prediction.
REQ-023 Reset SHALL abort any pending table update; no write SHALL occur on the first edge after release unless flush=1.

Configuration
REQ-024 With TP_STATS_EN defined, 32-bit outputs hitCount and flushCount SHALL count non-stalled cycles with hit=1 and with flush=1 respectively, saturating at all-ones and reset to 0; without it these ports and counters SHALL not exist.

Structure
REQ-025 Package tp_pkg SHALL hold the entry struct type, the reset PC constant 32'h1fc00000, and the merge function.
REQ-026 Sub-module tp_cam SHALL implement the match/priority-select logic and return hit and index.

Verification
REQ-027 Reset, vPC=0xbfc00000, pPCin=0x1fc00000, mask=0xffff -> pPCOut=0x1fc00000, flush=0 every cycle.
REQ-028 Jump to vPC=0x00400000, pPCin=0x01000000, mask=0 -> flush=1 next cycle with pPCOut=0x01000000; entry 0 written; revisit 0x00400010 later -> hit, pPCOut=0x01000010, flush=0.
REQ-029 Fill ENTRIES+1 distinct pages -> the first page is evicted (round-robin), revisiting it flushes once.
REQ-030 inval asserted with stall=1 during a pending flush -> all entries invalid after the edge, the first subsequent revisit is a miss.
REQ-031 asid change 1->2 with the same vPC -> miss/flush, both entries coexist, asid=1 then hits again.
REQ-032 TP_STATS_EN build: 3 hits and 2 flushes unstalled, 5 stalled cycles -> hitCount=3, flushCount=2.

Source files
------------

// File: rtl/tp_pkg.sv
// Shared types and helpers for the translate_predict_multi physical-PC predictor.
// Entry fields are sized for ASID_W <= 16 and MASK_W <= 16 (mask covers VA[27:12]).
package tp_pkg;

  localparam logic [31:0] RESET_PC = 32'h1fc0_0000;
  localparam int          ASID_MAX = 16;

  typedef struct packed {
    logic                valid;
    logic [ASID_MAX-1:0] asid;
    logic [15:0]         vpn;
    logic [15:0]         mask;
    logic [19:0]         ppn;
  } tp_entry_t;

  // Masked VA bits pass straight through; unmasked bits come from the translation.
  function automatic logic [31:0] tp_merge(input logic [19:0] ppn,
                                           input logic [15:0] mask,
                                           input logic [31:0] va);
    return {ppn[19:16], (ppn[15:0] & ~mask) | (va[27:12] & mask), va[11:0]};
  endfunction

endpackage

// File: rtl/tp_cam.sv
// Fully associative match over the prediction table; lowest matching index wins.
module tp_cam
  import tp_pkg::*;
#(
  parameter int ENTRIES = 4,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  tp_entry_t           entries [ENTRIES],
  input  logic [ASID_MAX-1:0] asid,
  input  logic [15:0]         vpn,
  output logic                hit,
  output logic [IDX_W-1:0]    idx
);

  // Scan downward so the last assignment is the lowest matching index.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].asid == asid) &&
          (((entries[i].vpn ^ vpn) & ~entries[i].mask) == 16'h0)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/translate_predict_multi.sv
// Zero-latency physical fetch-address predictor with one-cycle misprediction flush.
// Optional hit/flush statistics counters are enabled with TP_STATS_EN.
module translate_predict_multi
  import tp_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int MASK_W  = 16,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              inval,
  input  logic [ASID_W-1:0] asid,
  input  logic [31:0]       vPC,
  input  logic [MASK_W-1:0] pageMask,
  input  logic [31:0]       pPCin,
  output logic [31:0]       pPCOut,
  output logic              flush
`ifdef TP_STATS_EN
  ,
  output logic [31:0]       hitCount,
  output logic [31:0]       flushCount
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  tp_entry_t           entries_q [ENTRIES];
  logic [IDX_W-1:0]    rr_ptr;
  logic [31:0]         ppc_last;
  logic [15:0]         mask_last;
  logic [ASID_MAX-1:0] asid_q;
  logic [15:0]         vpn_q;
  logic [31:0]         pred_q;
  logic                hit_q;
  logic [IDX_W-1:0]    idx_q;

  logic [ASID_MAX-1:0] asid_x;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [31:0]         pred;
  tp_entry_t           wr_entry;
  logic [IDX_W-1:0]    wr_idx;

  assign asid_x = ASID_MAX'(asid);

  tp_cam #(.ENTRIES(ENTRIES)) u_cam (
    .entries (entries_q),
    .asid    (asid_x),
    .vpn     (vPC[27:12]),
    .hit     (hit),
    .idx     (hit_idx)
  );

  assign pred   = hit ? tp_merge(entries_q[hit_idx].ppn, entries_q[hit_idx].mask, vPC)
                      : tp_merge(ppc_last[31:12], mask_last, vPC);
  assign flush  = (ppc_last != pred_q);
  assign pPCOut = flush ? ppc_last : pred;

  // A wrong hit is corrected in place; only a wrong miss consumes the victim slot.
  always_comb begin
    wr_entry       = '0;
    wr_entry.valid = 1'b1;
    wr_entry.asid  = asid_q;
    wr_entry.vpn   = vpn_q;
    wr_entry.mask  = mask_last;
    wr_entry.ppn   = ppc_last[31:12];
    wr_idx         = hit_q ? idx_q : rr_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      rr_ptr <= '0;
    end else if (inval) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i].valid <= 1'b0;
    end else if (!stall && flush) begin
      entries_q[wr_idx] <= wr_entry;
      if (!hit_q) rr_ptr <= rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ppc_last  <= RESET_PC;
      mask_last <= '1;
      asid_q    <= '0;
      vpn_q     <= '0;
      pred_q    <= RESET_PC;
      hit_q     <= 1'b0;
      idx_q     <= '0;
    end else if (!stall) begin
      ppc_last  <= pPCin;
      mask_last <= 16'(pageMask);
      asid_q    <= asid_x;
      vpn_q     <= vPC[27:12];
      pred_q    <= pred;
      hit_q     <= hit;
      idx_q     <= hit_idx;
    end
  end

`ifdef TP_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt   <= '0;
      flush_cnt <= '0;
    end else if (!stall) begin
      if (hit && (hit_cnt != '1))     hit_cnt   <= hit_cnt + 32'd1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign hitCount   = hit_cnt;
  assign flushCount = flush_cnt;
`endif

endmodule

// File: tb/tb_translate_predict_multi.sv
// Directed plus randomized bench for translate_predict_multi with a reference model
// and expected-output queue; statistics ports are checked when TP_STATS_EN is defined.
module tb_translate_predict_multi;

  localparam int ENTRIES = 4;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        inval;
  logic [7:0]  asid;
  logic [31:0] vPC;
  logic [15:0] pageMask;
  logic [31:0] pPCin;
  logic [31:0] pPCOut;
  logic        flush;
`ifdef TP_STATS_EN
  logic [31:0] hitCount;
  logic [31:0] flushCount;
`endif

  translate_predict_multi #(.ENTRIES(ENTRIES), .MASK_W(16), .ASID_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .inval    (inval),
    .asid     (asid),
    .vPC      (vPC),
    .pageMask (pageMask),
    .pPCin    (pPCin),
    .pPCOut   (pPCOut),
    .flush    (flush)
`ifdef TP_STATS_EN
    ,
    .hitCount   (hitCount),
    .flushCount (flushCount)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  logic        m_valid [ENTRIES];
  logic [7:0]  m_asid  [ENTRIES];
  logic [15:0] m_vpn   [ENTRIES];
  logic [15:0] m_mask  [ENTRIES];
  logic [19:0] m_ppn   [ENTRIES];
  int          m_rr;
  logic [31:0] m_last;
  logic [15:0] m_mask_last;
  logic [7:0]  m_asid_q;
  logic [15:0] m_vpn_q;
  logic [31:0] m_pred_q;
  logic        m_hit_q;
  int          m_idx_q;
  logic        cur_hit;
  int          cur_idx;
  logic [31:0] cur_pred;
  logic        m_flush;
  int          m_hits;
  int          m_flushes;

  // scoreboard
  logic [32:0] exp_q [$];
  int          n_checks;
  int          n_fail;
  logic [31:0] obs_pc;
  logic        obs_flush;

  function automatic logic [31:0] ref_merge(input logic [19:0] ppn, input logic [15:0] mask,
                                            input logic [31:0] va);
    logic [31:0] base;
    logic [31:0] keep_va;
    base    = {ppn, 12'h000};
    keep_va = {4'h0, mask, 12'hfff};
    return (base & ~keep_va) | (va & keep_va);
  endfunction

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_asid[i] = '0; m_vpn[i] = '0; m_mask[i] = '0; m_ppn[i] = '0;
    end
    m_rr = 0; m_last = 32'h1fc0_0000; m_mask_last = 16'hffff; m_asid_q = '0;
    m_vpn_q = '0; m_pred_q = 32'h1fc0_0000; m_hit_q = 1'b0; m_idx_q = 0;
    m_hits = 0; m_flushes = 0;
  endtask

  task automatic model_eval(input logic [7:0] a, input logic [31:0] va);
    cur_hit = 1'b0;
    cur_idx = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!cur_hit && m_valid[i] && m_asid[i] == a &&
          (m_vpn[i] & ~m_mask[i]) == (va[27:12] & ~m_mask[i])) begin
        cur_hit = 1'b1;
        cur_idx = i;
      end
    end
    cur_pred = cur_hit ? ref_merge(m_ppn[cur_idx], m_mask[cur_idx], va)
                       : ref_merge(m_last[31:12], m_mask_last, va);
    m_flush  = (m_last != m_pred_q);
  endtask

  task automatic model_edge(input logic st, input logic inv, input logic [7:0] a,
                            input logic [31:0] va, input logic [15:0] m, input logic [31:0] pa);
    int w;
    if (inv) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else if (!st && m_flush) begin
      w = m_hit_q ? m_idx_q : m_rr;
      m_valid[w] = 1'b1; m_asid[w] = m_asid_q; m_vpn[w] = m_vpn_q;
      m_mask[w] = m_mask_last; m_ppn[w] = m_last[31:12];
      if (!m_hit_q) m_rr = (m_rr + 1) % ENTRIES;
    end
    if (!st) begin
      m_last = pa; m_mask_last = m; m_asid_q = a; m_vpn_q = va[27:12];
      m_pred_q = cur_pred; m_hit_q = cur_hit; m_idx_q = cur_idx;
    end
  endtask

  // driver: called just after a falling edge, returns just after the next falling edge
  task automatic step(input logic st, input logic inv, input logic [7:0] a,
                      input logic [31:0] va, input logic [15:0] m, input logic [31:0] pa);
    logic [32:0] exp;
    stall = st; inval = inv; asid = a; vPC = va; pageMask = m; pPCin = pa;
    model_eval(a, va);
    exp_q.push_back({m_flush, m_flush ? m_last : cur_pred});
    if (!st && cur_hit) m_hits++;
    if (!st && m_flush) m_flushes++;
    #1;
    obs_pc = pPCOut;
    obs_flush = flush;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 33'd1, 33'd0);
    end else begin
      exp = exp_q.pop_front();
      chk("model_out", {flush, pPCOut}, exp);
    end
    @(posedge clk);
    model_edge(st, inv, a, va, m, pa);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] va;
    logic [7:0]  a;
    n_checks = 0; n_fail = 0;
    model_reset();
    rst_n = 1'b0; stall = 1'b0; inval = 1'b0; asid = 8'd1;
    vPC = 32'hbfc0_0000; pageMask = 16'hffff; pPCin = 32'h1fc0_0000;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_pc", {1'b0, pPCOut}, {1'b0, 32'h1fc0_0000});
    chk("reset_flush", {32'h0, flush}, 33'd0);
    rst_n = 1'b1;

    // boot region: predictions always right
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'd1, 32'hbfc0_0000 + 32'(4 * i), 16'hffff, 32'h1fc0_0000 + 32'(4 * i));
      chk("boot_pc", {1'b0, obs_pc}, {1'b0, 32'h1fc0_0000 + 32'(4 * i)});
      chk("boot_flush", {32'h0, obs_flush}, 33'd0);
    end

    // jump to a new page: one-cycle-late flush with correction
    step(0, 0, 8'd1, 32'h0040_0000, 16'h0000, 32'h0100_0000);
    step(0, 0, 8'd1, 32'h0040_0004, 16'h0000, 32'h0100_0004);
    chk("jump_flush", {32'h0, obs_flush}, 33'd1);
    chk("jump_pc", {1'b0, obs_pc}, {1'b0, 32'h0100_0000});
    step(0, 0, 8'd1, 32'h0050_0000, 16'h0000, 32'h0110_0000);
    step(0, 0, 8'd1, 32'h0050_0004, 16'h0000, 32'h0110_0004);
    step(0, 0, 8'd1, 32'h0040_0010, 16'h0000, 32'h0100_0010);
    chk("revisit_hit_pc", {1'b0, obs_pc}, {1'b0, 32'h0100_0010});
    chk("revisit_hit_flush", {32'h0, obs_flush}, 33'd0);
    step(0, 0, 8'd1, 32'h0040_0014, 16'h0000, 32'h0100_0014);
    chk("after_hit_flush", {32'h0, obs_flush}, 33'd0);

    // fill the rest so page 0x0040 is evicted round-robin
    for (int p = 6; p <= 8; p++) begin
      va = 32'(p) << 20;
      step(0, 0, 8'd1, va, 16'h0000, va + 32'h00c0_0000);
      step(0, 0, 8'd1, va + 32'd4, 16'h0000, va + 32'h00c0_0004);
      chk("fill_flush", {32'h0, obs_flush}, 33'd1);
    end
    step(0, 0, 8'd1, 32'h0040_0020, 16'h0000, 32'h0100_0020);
    chk("evicted_miss_pc", {1'b0, obs_pc}, {1'b0, 32'h0140_0020});
    step(0, 0, 8'd1, 32'h0040_0024, 16'h0000, 32'h0100_0024);
    chk("evicted_flush", {32'h0, obs_flush}, 33'd1);
    chk("evicted_pc", {1'b0, obs_pc}, {1'b0, 32'h0100_0020});
    step(0, 0, 8'd1, 32'h0040_0028, 16'h0000, 32'h0100_0028);
    chk("evicted_flush_once", {32'h0, obs_flush}, 33'd0);

    // invalidate under stall while a flush is pending
    step(0, 0, 8'd1, 32'h0090_0000, 16'h0000, 32'h0150_0000);
    step(1, 1, 8'd1, 32'h0090_0004, 16'h0000, 32'h0150_0004);
    chk("stall_inval_flush", {32'h0, obs_flush}, 33'd1);
    step(1, 0, 8'd1, 32'h0090_0004, 16'h0000, 32'h0150_0004);
    chk("stall_hold_pc", {1'b0, obs_pc}, {1'b0, 32'h0150_0000});
    step(0, 0, 8'd1, 32'h0080_0000, 16'h0000, 32'h0140_0000);
    step(0, 0, 8'd1, 32'h0080_0004, 16'h0000, 32'h0140_0004);
    chk("post_inval_miss_flush", {32'h0, obs_flush}, 33'd1);
    chk("post_inval_miss_pc", {1'b0, obs_pc}, {1'b0, 32'h0140_0000});
    step(0, 0, 8'd1, 32'h0080_0008, 16'h0000, 32'h0140_0008);

    // address spaces coexist
    step(0, 0, 8'd2, 32'h0080_0010, 16'h0000, 32'h0340_0010);
    step(0, 0, 8'd2, 32'h0080_0014, 16'h0000, 32'h0340_0014);
    chk("asid_flush", {32'h0, obs_flush}, 33'd1);
    chk("asid_pc", {1'b0, obs_pc}, {1'b0, 32'h0340_0010});
    step(0, 0, 8'd1, 32'h0080_0020, 16'h0000, 32'h0140_0020);
    chk("asid1_hit_pc", {1'b0, obs_pc}, {1'b0, 32'h0140_0020});
    chk("asid1_hit_flush", {32'h0, obs_flush}, 33'd0);
    step(0, 0, 8'd2, 32'h0080_0030, 16'h0000, 32'h0340_0030);
    chk("asid2_hit_pc", {1'b0, obs_pc}, {1'b0, 32'h0340_0030});

    // large page: masked VA bits pass through on a hit
    step(0, 0, 8'd1, 32'h0123_0000, 16'h00ff, 32'h05f3_0000);
    step(0, 0, 8'd1, 32'h0123_0004, 16'h00ff, 32'h05f3_0004);
    step(0, 0, 8'd1, 32'h0080_0040, 16'h0000, 32'h0140_0040);
    step(0, 0, 8'd1, 32'h012a_5678, 16'h00ff, 32'h05fa_5678);
    chk("mask_hit_pc", {1'b0, obs_pc}, {1'b0, 32'h05fa_5678});
    chk("mask_hit_flush", {32'h0, obs_flush}, 33'd0);

    // randomized traffic over a small page set, two address spaces
    for (int i = 0; i < 60; i++) begin
      a  = 8'($urandom_range(1, 2));
      va = (32'($urandom_range(4, 8)) << 20) | 32'($urandom_range(0, 4095) & 32'hffc);
      step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 15) == 0), a, va,
           16'h0000, va + ((a == 8'd1) ? 32'h00c0_0000 : 32'h02c0_0000));
    end

`ifdef TP_STATS_EN
    chk("hit_count", {1'b0, hitCount}, {1'b0, 32'(m_hits)});
    chk("flush_count", {1'b0, flushCount}, {1'b0, 32'(m_flushes)});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
